// File: rtl/detect_run_1s_if.sv
// Sample and result bundle for detect_run_1s: serial input controls on one side,
// detection pulse, run length and hit counter on the other.
interface detect_run_1s_if #(
  parameter int CW = 8
);
  logic          din;
  logic          en;
  logic          mode;
  logic          clr;
  logic          dout;
  logic [3:0]    run_len;
  logic [CW-1:0] hit_cnt;

  modport master (
    output din, en, mode, clr,
    input  dout, run_len, hit_cnt
  );

  modport slave (
    input  din, en, mode, clr,
    output dout, run_len, hit_cnt
  );
endinterface

// File: rtl/detect_run_1s.sv
// Detects runs of N consecutive qualified 1s on a serial input, in overlapping
// or non-overlapping mode, with a registered pulse and a saturating hit counter.
module detect_run_1s #(
  parameter int N  = 2,
  parameter int CW = 8
) (
  input  logic           ck,
  input  logic           rst,
  detect_run_1s_if.slave bus
);

  localparam logic [3:0] RUN_MAX = 4'(N);
  localparam logic [3:0] RUN_HIT = 4'(N - 1);

  logic [3:0]    r_q, r_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    r_d       = r_q;
    dout_d    = 1'b0;
    hit_cnt_d = hit_cnt_q;
    if (bus.clr) begin
      r_d       = '0;
      hit_cnt_d = '0;
    end else if (bus.en) begin
      if (!bus.din) begin
        r_d = '0;
      end else if (r_q >= RUN_HIT) begin
        // Overlapping mode parks at N so every further 1 detects again.
        dout_d = 1'b1;
        r_d    = bus.mode ? 4'd0 : RUN_MAX;
        if (hit_cnt_q != '1) begin
          hit_cnt_d = hit_cnt_q + 1'b1;
        end
      end else begin
        r_d = r_q + 4'd1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      dout_q    <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      r_q       <= r_d;
      dout_q    <= dout_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.run_len = r_q;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: doc/detect_run_1s.md
DETECT_RUN_1S -- requirements
Module: detect_run_1s

Interface
REQ-001 Parameter N, default 2, SHALL set the required run length of consecutive 1s; legal range 2..15.
REQ-002 Parameter CW, default 8, SHALL set the width of the detection counter hit_cnt.
REQ-003 ck  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset (0 = reset).
REQ-005 din  input  1  SHALL be the serial data bit, sampled on the rising edge of ck.
REQ-006 en  input  1  SHALL be the sample-valid qualifier; din is ignored when en=0.
REQ-007 mode  input  1  SHALL select detection mode: 0 = overlapping, 1 = non-overlapping.
REQ-008 clr  input  1  SHALL be a synchronous clear of hit_cnt and run state.
REQ-009 dout  output  1  SHALL be the registered detection pulse.
REQ-010 run_len  output  4  SHALL report the current consecutive-1 count, saturating at N.
REQ-011 hit_cnt  output  CW  SHALL report the number of detections since reset or clr.

Function
REQ-012 The internal run counter r SHALL range 0..N; run_len SHALL equal r.
REQ-013 On an edge with en=1 and din=0, the block SHALL set r=0 and dout=0.
REQ-014 On an edge with en=1, din=1 and r<N-1, the block SHALL set r=r+1 and dout=0.
REQ-015 On an edge with en=1, din=1 and r>=N-1, a detection SHALL occur, with dout=1 in the following cycle (latency 1 cycle from the sampling edge).
REQ-016 On a detection with mode=0, r SHALL become N, and each further 1 SHALL produce another detection.
REQ-017 On a detection with mode=1, r SHALL become 0, so the next detection needs N fresh 1s.
REQ-018 On an edge with en=0, r SHALL hold and dout SHALL be 0; an en=0 gap SHALL NOT break a run.
REQ-019 Each detection SHALL increment hit_cnt by 1, saturating at 2^CW-1 with no wrap.
REQ-020 clr=1 SHALL set r=0, hit_cnt=0 and dout=0 on that edge, overriding en/din, including a coincident detection.
REQ-021 A mode change SHALL take effect on the edge at which it is sampled, without clearing r; if r=N when mode goes to 1, the next 1 SHALL detect and set r=0.
REQ-022 dout SHALL depend only on registered state; no combinational path from din to dout.

Reset
REQ-023 rst=0 SHALL immediately, without waiting for ck, force r=0, run_len=0, dout=0 and hit_cnt=0.
REQ-024 While rst=0, all inputs SHALL be ignored.
REQ-025 After rst rises, the first sampled din SHALL count as bit 1 of a new run.
REQ-026 Reset asserted mid-run or mid-pulse SHALL discard the partial run with no spurious dout.

Verification
REQ-027 N=2, mode=0, en=1, din sequence 1,0,1,1,1,0,0,1,0,1 -> dout=1 in the cycles after samples 4 and 5 only, hit_cnt=2.
REQ-028 Same sequence with mode=1 -> dout=1 after sample 4 only, hit_cnt=1, run_len=1 after sample 5.
REQ-029 N=3, mode=0, din=1,1,en=0 for 3 cycles, then din=1 -> no dout during the gap, dout=1 after the third 1, run_len=3.
REQ-030 CW=2, mode=0, 8 consecutive 1s with N=2 -> 7 detections, hit_cnt saturates at 3, dout still pulses.
REQ-031 rst pulled low between edges during a run with run_len=1 -> outputs 0 immediately, then din=1 after release gives run_len=1 and no dout.
REQ-032 clr=1 on the same edge as a would-be detection -> dout=0, hit_cnt=0, run_len=0 on the next cycle.
